// File: rtl/ysyx_24080006_mdu_ctrl_pkg.sv
// Shared MDU types: operation encoding, ALU borrow interface and sequencer states.
package ysyx_24080006_mdu_ctrl_pkg;

    localparam int XLEN      = 32;
    localparam int MUL_STEPS = 33;
    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        MULL = 2'd0,
        MULH = 2'd1,
        DIV  = 2'd2,
        REM  = 2'd3
    } mdu_op_e;

    typedef struct packed {
        logic    mdu_enable;
        logic    signed_a;
        logic    signed_b;
        mdu_op_e mdu_op;
    } mdu_set_t;

    typedef struct packed {
        logic [XLEN:0] a;
        logic [XLEN:0] b;
    } mdu2alu_t;

    typedef struct packed {
        logic [XLEN+1:0] res_34;
    } alu2mdu_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div_op(input mdu_op_e op);
        return (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_sign.sv
// Operand preparation and result sign correction around the unsigned MDU core.
// Multiply operands are only widened (signed or zero extended to 33 bits);
// divide operands are reduced to magnitudes and the result signs are
// restored afterwards from flags captured when the op was accepted.
module ysyx_24080006_mdu_sign
    import ysyx_24080006_mdu_ctrl_pkg::*;
(
    input  logic            signed_a,
    input  logic            signed_b,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN:0]   mcand_ext,
    output logic [XLEN:0]   mplier_ext,
    output logic [XLEN-1:0] dvd_mag,
    output logic [XLEN:0]   dvs_mag,
    output logic            neg_q,
    output logic            neg_r,
    input  logic            neg_q_held,
    input  logic            neg_r_held,
    input  logic [XLEN-1:0] raw_q,
    input  logic [XLEN-1:0] raw_r,
    output logic [XLEN-1:0] fix_q,
    output logic [XLEN-1:0] fix_r
);

    logic neg_a;
    logic neg_b;

    // Widen multiply operands and form divide magnitudes with a local negator.
    always_comb begin
        neg_a      = signed_a & rs1[XLEN-1];
        neg_b      = signed_a & rs2[XLEN-1];
        mcand_ext  = {signed_a & rs1[XLEN-1], rs1};
        mplier_ext = {signed_b & rs2[XLEN-1], rs2};
        dvd_mag    = neg_a ? (~rs1 + XLEN'(1)) : rs1;
        dvs_mag    = {1'b0, (neg_b ? (~rs2 + XLEN'(1)) : rs2)};
        neg_q      = neg_a ^ neg_b;
        neg_r      = neg_a;
    end

    // Quotient is negated when operand signs differ; remainder follows the dividend.
    always_comb begin
        fix_q = neg_q_held ? (~raw_q + XLEN'(1)) : raw_q;
        fix_r = neg_r_held ? (~raw_r + XLEN'(1)) : raw_r;
    end

endmodule

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// Multi-cycle M-extension sequencer. It owns no adder: every iteration
// borrows the shared EXU adder through mdu2alu/alu2mdu while mdu_busy is high.
// Multiply is a 33-step shift-add on 33-bit extended operands (the last step
// subtracts to give the sign bit its negative weight); divide is a 32-step
// restoring divide on magnitudes. Divide-by-zero and signed overflow are
// resolved in IDLE without touching the ALU.
module ysyx_24080006_mdu_ctrl
    import ysyx_24080006_mdu_ctrl_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  mdu_set_t        mdu_set,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output mdu2alu_t        mdu2alu,
    output logic            alu_sub,
    output logic            mdu_busy,
    input  alu2mdu_t        alu2mdu,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    mdu_state_e      state;
    mdu_state_e      state_next;
    logic [5:0]      counter;
    logic [XLEN:0]   acc;
    logic [XLEN:0]   shreg;
    logic [XLEN:0]   opb;
    mdu_op_e         op_q;
    logic            neg_q_q;
    logic            neg_r_q;

    logic            accept;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic            is_mul_q;
    logic            last_step;

    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   step_a;
    logic [XLEN:0]   step_b;
    logic            step_sub;
    logic [XLEN:0]   acc_next;
    logic [XLEN:0]   shreg_next;
    logic [XLEN-1:0] calc_res;

    logic [XLEN:0]   mcand_ext;
    logic [XLEN:0]   mplier_ext;
    logic [XLEN-1:0] dvd_mag;
    logic [XLEN:0]   dvs_mag;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] fix_q;
    logic [XLEN-1:0] fix_r;

    ysyx_24080006_mdu_sign u_sign (
        .signed_a   (mdu_set.signed_a),
        .signed_b   (mdu_set.signed_b),
        .rs1        (rs1),
        .rs2        (rs2),
        .mcand_ext  (mcand_ext),
        .mplier_ext (mplier_ext),
        .dvd_mag    (dvd_mag),
        .dvs_mag    (dvs_mag),
        .neg_q      (neg_q),
        .neg_r      (neg_r),
        .neg_q_held (neg_q_q),
        .neg_r_held (neg_r_q),
        .raw_q      (shreg_next[XLEN-1:0]),
        .raw_r      (acc_next[XLEN-1:0]),
        .fix_q      (fix_q),
        .fix_r      (fix_r)
    );

    // Accept decision and the divide corner cases that bypass the iteration.
    always_comb begin
        accept   = (state == IDLE) && in_valid && mdu_set.mdu_enable && !kill;
        div_zero = (rs2 == '0);
        div_ovf  = mdu_set.signed_a && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        special  = is_div_op(mdu_set.mdu_op) && (div_zero || div_ovf);
        if (mdu_set.mdu_op == DIV) begin
            special_res = div_zero ? '1 : rs1;
        end else begin
            special_res = div_zero ? rs1 : '0;
        end
        is_mul_q  = !is_div_op(op_q);
        last_step = is_mul_q ? (counter == 6'(MUL_STEPS - 1))
                             : (counter == 6'(DIV_STEPS - 1));
    end

    // One iteration: choose adder operands and fold the adder result back in.
    always_comb begin
        rem_shift = {acc[XLEN-1:0], shreg[XLEN-1]};
        if (is_mul_q) begin
            step_a     = acc;
            step_b     = shreg[0] ? opb : '0;
            step_sub   = last_step;
            acc_next   = alu2mdu.res_34[XLEN+1:1];
            shreg_next = {alu2mdu.res_34[0], shreg[XLEN:1]};
        end else begin
            step_a     = rem_shift;
            step_b     = opb;
            step_sub   = 1'b1;
            acc_next   = alu2mdu.res_34[XLEN+1] ? rem_shift : alu2mdu.res_34[XLEN:0];
            shreg_next = {1'b0, shreg[XLEN-2:0], ~alu2mdu.res_34[XLEN+1]};
        end
        case (op_q)
            MULL:    calc_res = shreg_next[XLEN-1:0];
            MULH:    calc_res = {acc_next[XLEN-2:0], shreg_next[XLEN]};
            DIV:     calc_res = fix_q;
            default: calc_res = fix_r;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; kill returns to IDLE from anywhere.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = special ? DONE : CALC;
            CALC: begin
                if (kill) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: if (kill || out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs; the adder inputs are forced to zero outside CALC.
    always_comb begin
        in_ready  = (state == IDLE);
        mdu_busy  = (state == CALC);
        out_valid = (state == DONE) && !kill;
        alu_sub   = (state == CALC) && step_sub;
        mdu2alu   = '0;
        if (state == CALC) begin
            mdu2alu.a = step_a;
            mdu2alu.b = step_b;
        end
    end

    // Operand latch, iteration registers, step counter and result register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
            acc     <= '0;
            shreg   <= '0;
            opb     <= '0;
            op_q    <= MULL;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            result  <= '0;
        end else if (accept) begin
            counter <= '0;
            acc     <= '0;
            op_q    <= mdu_set.mdu_op;
            neg_q_q <= neg_q;
            neg_r_q <= neg_r;
            if (is_div_op(mdu_set.mdu_op)) begin
                shreg <= {1'b0, dvd_mag};
                opb   <= dvs_mag;
            end else begin
                shreg <= mplier_ext;
                opb   <= mcand_ext;
            end
            if (special) begin
                result <= special_res;
            end
        end else if ((state == CALC) && !kill) begin
            acc     <= acc_next;
            shreg   <= shreg_next;
            counter <= counter + 6'd1;
            if (last_step) begin
                result <= calc_res;
            end
        end else begin
            counter <= '0;
        end
    end

endmodule
